// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  in_if_req;
  logic [ADDR_WIDTH-1:0] in_if_addr;
  logic                  in_flush;
  logic                  in_dm_read;
  logic                  in_dm_write;
  logic [ADDR_WIDTH-1:0] in_dm_addr;
  logic [DATA_WIDTH-1:0] in_dm_wdata;
  logic [DATA_WIDTH-1:0] in_mem_rdata;
  logic                  in_mem_ready;
  logic                  out_mem_req;
  logic                  out_mem_we;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [DATA_WIDTH-1:0] out_mem_wdata;
  logic [DATA_WIDTH-1:0] out_if_rdata;
  logic                  out_if_valid;
  logic [DATA_WIDTH-1:0] out_dm_rdata;
  logic                  out_dm_done;
  logic                  out_stall_if;
  logic                  out_stall_mem;
  logic                  out_error;

  modport master (
    input  in_if_req, in_if_addr, in_flush, in_dm_read, in_dm_write, in_dm_addr,
           in_dm_wdata, in_mem_rdata, in_mem_ready,
    output out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_if_rdata,
           out_if_valid, out_dm_rdata, out_dm_done, out_stall_if, out_stall_mem, out_error
  );

  modport slave (
    output in_if_req, in_if_addr, in_flush, in_dm_read, in_dm_write, in_dm_addr,
           in_dm_wdata, in_mem_rdata, in_mem_ready,
    input  out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_if_rdata,
           out_if_valid, out_dm_rdata, out_dm_done, out_stall_if, out_stall_mem, out_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, sequences the handshake and generates pipeline stalls
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic                in_clk,
  input logic                in_rst_n,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, ERROR} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  dm_req, busy, dm_hit, if_hit;

  assign dm_req = bus.in_dm_read | bus.in_dm_write;
  assign busy   = (state_q == FETCH) || (state_q == DATA);
  assign dm_hit = (state_q == DATA) && bus.in_mem_ready;
  assign if_hit = (state_q == FETCH) && bus.in_mem_ready && !drop_q;

  // state and latched access registers; reset aborts any access in flight
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // grant (data before fetch, since the load/store is the older instruction), completion and watchdog
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          addr_d  = bus.in_dm_addr;
          wdata_d = bus.in_dm_wdata;
          we_d    = bus.in_dm_write;
          cnt_d   = '0;
          state_d = DATA;
        end else if (bus.in_if_req && !bus.in_flush) begin
          addr_d  = bus.in_if_addr;
          we_d    = 1'b0;
          drop_d  = 1'b0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH, DATA: begin
        if (state_q == FETCH && bus.in_flush) drop_d = 1'b1;
        if (bus.in_mem_ready) state_d = IDLE;
        else if (cnt_q == TMO_LAST) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.out_mem_req   = busy;
  assign bus.out_mem_we    = we_q;
  assign bus.out_mem_addr  = addr_q;
  assign bus.out_mem_wdata = wdata_q;
  assign bus.out_if_rdata  = bus.in_mem_rdata;
  assign bus.out_dm_rdata  = bus.in_mem_rdata;
  assign bus.out_if_valid  = if_hit & !bus.in_flush;
  assign bus.out_dm_done   = dm_hit;
  assign bus.out_stall_mem = dm_req & !dm_hit;
  assign bus.out_stall_if  = bus.out_stall_mem | (bus.in_if_req & !if_hit);
  assign bus.out_error     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared memory port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if b ();
  mem_port_arbiter #(.TIMEOUT(4)) dut (.in_clk(clk), .in_rst_n(rst_n), .bus(b));

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // completion monitor: every strobe pops the oldest expected access
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (b.out_dm_done || b.out_if_valid)) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("cmp_kind", b.out_dm_done, e.is_dm);
        chk("cmp_both", b.out_dm_done & b.out_if_valid, 0);
        chk("cmp_addr", b.out_mem_addr, e.addr);
        chk("cmp_we", b.out_mem_we, e.we);
        if (e.is_dm && !e.we) chk("load_data", b.out_dm_rdata, e.data);
        if (!e.is_dm) chk("fetch_data", b.out_if_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access_dm(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits);
    b.in_dm_read = !we; b.in_dm_write = we; b.in_dm_addr = addr; b.in_dm_wdata = wdata;
    b.in_mem_ready = 1'b0;
    sb.push_back('{1'b1, we, addr, rdata});
    @(negedge clk);
    chk("dm_idle_stall", b.out_stall_mem, 1);
    chk("dm_idle_req", b.out_mem_req, 0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      b.in_mem_ready = (i == waits);
      b.in_mem_rdata = (i == waits) ? rdata : $urandom;
      b.in_dm_addr = $urandom;
      b.in_dm_wdata = $urandom;
      @(negedge clk);
      chk("dm_req", b.out_mem_req, 1);
      chk("dm_addr_stable", b.out_mem_addr, addr);
      chk("dm_wdata", b.out_mem_wdata, wdata);
      chk("dm_stall", b.out_stall_mem, 32'(i != waits));
      chk("dm_done", b.out_dm_done, 32'(i == waits));
    end
    tick();
    b.in_dm_read = 1'b0; b.in_dm_write = 1'b0; b.in_mem_ready = 1'b0;
  endtask

  task automatic access_if(input logic [31:0] addr, input logic [31:0] rdata,
                           input int waits, input int flush_at);
    bit dropped;
    b.in_if_req = 1'b1; b.in_if_addr = addr; b.in_mem_ready = 1'b0;
    if (flush_at < 0) sb.push_back('{1'b0, 1'b0, addr, rdata});
    @(negedge clk);
    chk("if_idle_stall", b.out_stall_if, 1);
    chk("if_idle_req", b.out_mem_req, 0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      b.in_mem_ready = (i == waits);
      b.in_mem_rdata = (i == waits) ? rdata : $urandom;
      b.in_flush = (i == flush_at);
      b.in_if_addr = $urandom;
      dropped = (flush_at >= 0) && (flush_at < i);
      @(negedge clk);
      chk("if_req", b.out_mem_req, 1);
      chk("if_addr_stable", b.out_mem_addr, addr);
      chk("if_we", b.out_mem_we, 0);
      chk("if_stall", b.out_stall_if, 32'(!(i == waits && !dropped)));
      chk("if_valid", b.out_if_valid, 32'(i == waits && flush_at < 0));
    end
    tick();
    b.in_if_req = 1'b0; b.in_flush = 1'b0; b.in_mem_ready = 1'b0;
  endtask

  initial begin
    b.in_if_req = 0; b.in_if_addr = 0; b.in_flush = 0; b.in_dm_read = 0; b.in_dm_write = 0;
    b.in_dm_addr = 0; b.in_dm_wdata = 0; b.in_mem_rdata = 0; b.in_mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", b.out_mem_req, 0);
    chk("rst_we", b.out_mem_we, 0);
    chk("rst_addr", b.out_mem_addr, 0);
    chk("rst_wdata", b.out_mem_wdata, 0);
    chk("rst_valid", b.out_if_valid, 0);
    chk("rst_done", b.out_dm_done, 0);
    chk("rst_error", b.out_error, 0);
    tick();
    rst_n = 1'b1;
    tick();
    access_if(32'h100, 32'h0000_0013, 0, -1);
    access_dm(1'b0, 32'h2000, 32'h0, 32'hDEAD_BEEF, 3);
    access_dm(1'b1, 32'h300, 32'h1234_5678, 32'h0, 1);
    // store and fetch together: store first, one idle cycle, then fetch
    b.in_dm_write = 1; b.in_dm_addr = 32'h40; b.in_dm_wdata = 32'hCAFE_F00D;
    b.in_if_req = 1; b.in_if_addr = 32'h104;
    sb.push_back('{1'b1, 1'b1, 32'h40, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h104, 32'h00A0_0093});
    @(negedge clk);
    chk("both_stall_if", b.out_stall_if, 1);
    chk("both_stall_mem", b.out_stall_mem, 1);
    for (int i = 0; i <= 1; i++) begin
      tick();
      b.in_mem_ready = (i == 1);
      @(negedge clk);
      chk("both_st_we", b.out_mem_we, 1);
      chk("both_st_addr", b.out_mem_addr, 32'h40);
      chk("both_st_stall_if", b.out_stall_if, 1);
      chk("both_st_stall_mem", b.out_stall_mem, 32'(i != 1));
    end
    tick();
    b.in_dm_write = 0; b.in_mem_ready = 0;
    @(negedge clk);
    chk("both_gap_req", b.out_mem_req, 0);
    chk("both_gap_stall_if", b.out_stall_if, 1);
    for (int i = 0; i <= 1; i++) begin
      tick();
      b.in_mem_ready = (i == 1);
      b.in_mem_rdata = (i == 1) ? 32'h00A0_0093 : 32'h0BAD_0BAD;
      @(negedge clk);
      chk("both_f_addr", b.out_mem_addr, 32'h104);
      chk("both_f_we", b.out_mem_we, 0);
      chk("both_f_stall_if", b.out_stall_if, 32'(i != 1));
    end
    tick();
    b.in_if_req = 0; b.in_mem_ready = 0;
    access_if(32'h200, 32'h1111_1111, 3, 1);
    access_if(32'h400, 32'h2222_2222, 1, -1);
    access_if(32'h500, 32'h3333_3333, 2, 2);
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: access_if({$urandom} & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3), -1);
        1: access_dm(1'b0, $urandom, 32'h0, $urandom, $urandom_range(0, 3));
        default: access_dm(1'b1, $urandom, $urandom, 32'h0, $urandom_range(0, 3));
      endcase
    end
    // reset in the middle of a data access
    b.in_dm_read = 1; b.in_dm_addr = 32'h800;
    tick();
    tick();
    @(negedge clk);
    chk("mid_req", b.out_mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_req", b.out_mem_req, 0);
    chk("mid_rst_addr", b.out_mem_addr, 0);
    b.in_dm_read = 0;
    tick();
    rst_n = 1'b1;
    access_dm(1'b0, 32'h900, 32'h0, 32'hA5A5_5A5A, 1);
    // watchdog: memory never answers
    b.in_dm_read = 1; b.in_dm_addr = 32'hF00; b.in_if_req = 1; b.in_if_addr = 32'h600;
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      chk("to_wait_req", b.out_mem_req, 1);
      chk("to_wait_err", b.out_error, 0);
    end
    tick();
    @(negedge clk);
    chk("to_err", b.out_error, 1);
    chk("to_req", b.out_mem_req, 0);
    chk("to_stall_mem", b.out_stall_mem, 1);
    chk("to_stall_if", b.out_stall_if, 1);
    tick();
    b.in_mem_ready = 1;
    @(negedge clk);
    chk("to_sticky", b.out_error, 1);
    chk("to_no_grant", b.out_mem_req, 0);
    chk("to_no_done", b.out_dm_done, 0);
    b.in_dm_read = 0; b.in_if_req = 0; b.in_mem_ready = 0;
    #2 rst_n = 1'b0;
    #1 chk("to_rst_err", b.out_error, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("to_rst_req", b.out_mem_req, 0);
    tick();
    access_if(32'h700, 32'h4444_4444, 0, -1);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and stall sequencer for the pipelined RISC-V core. It shares one unified instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (loads/stores from EX/MEM). It sequences the bus handshake and generates the pipeline freeze signals that hold PC, IF/ID and the upstream registers while an access is outstanding. The block sits beside the hazard and forwarding logic and feeds the pipeline-register enables.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory word width
- TIMEOUT, 255, max wait cycles for in_mem_ready before error (8-bit counter, 1..255)

- in_clk  input  1  single clock, rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_if_req  input  1  fetch request from IF
- in_if_addr  input  ADDR_WIDTH  fetch address (PC)
- in_flush  input  1  taken branch/jump; discard in-flight fetch
- in_dm_read  input  1  load in MEM stage (EX/MEM memread)
- in_dm_write  input  1  store in MEM stage (EX/MEM memwrite)
- in_dm_addr  input  ADDR_WIDTH  data address
- in_dm_wdata  input  DATA_WIDTH  store data
- in_mem_rdata  input  DATA_WIDTH  memory read data
- in_mem_ready  input  1  memory completes the current access this cycle
- out_mem_req  output  1  access request to memory
- out_mem_we  output  1  write enable
- out_mem_addr  output  ADDR_WIDTH  latched access address
- out_mem_wdata  output  DATA_WIDTH  latched store data
- out_if_rdata  output  DATA_WIDTH  fetched instruction
- out_if_valid  output  1  fetch result valid (one cycle)
- out_dm_rdata  output  DATA_WIDTH  load data
- out_dm_done  output  1  data access (load or store) completes (one cycle)
- out_stall_if  output  1  freeze PC and IF/ID
- out_stall_mem  output  1  freeze ID/EX, EX/MEM and everything upstream
- out_error  output  1  sticky timeout flag

## Operation
- FSM states: IDLE, FETCH, DATA, ERROR.
- IDLE: if in_dm_read|in_dm_write, latch dm addr/wdata and set we=in_dm_write, then go to DATA. Otherwise, if in_if_req and !in_flush, latch in_if_addr, clear drop flag, then go to FETCH. Data always has priority because the instruction is older.
- FETCH/DATA: out_mem_req=1, and addr/we/wdata are driven from the latched registers, so they stay stable until completion. On the first cycle with in_mem_ready=1 the access completes and the FSM returns to IDLE (one turnaround cycle). There is no preemption.
- Completion in DATA: out_dm_done=1. For a load, out_dm_rdata=in_mem_rdata, combinational, in the same cycle.
- Completion in FETCH: out_if_rdata=in_mem_rdata. out_if_valid=1 unless the drop flag is set or in_flush=1 this cycle.
- in_flush during FETCH sets the drop flag. The bus access still runs to completion and its result is discarded.
- Stalls, combinational:
  - out_stall_mem = (in_dm_read|in_dm_write) & !(DATA & in_mem_ready)
  - out_stall_if = out_stall_mem | (in_if_req & !(FETCH & in_mem_ready & !drop))
- Stalls drop in the completion cycle, so the pipeline advances at that clock edge.
- If a store and a fetch are both pending, the store goes first and IF stays stalled throughout.
- Watchdog: an 8-bit counter clears on entry to FETCH/DATA and increments each cycle while waiting.
  - If it reaches TIMEOUT without in_mem_ready, go to ERROR and set out_error.
  - ERROR: out_mem_req=0, stalls held asserted per the equations, no new grants. Only reset exits.
- Reset (asynchronous, any state, including mid-access): FSM to IDLE, counter and drop flag to 0, all registered outputs to 0. out_mem_req deasserts immediately with no handshake completion.

## Timing
- Reset values: out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_if_valid, out_dm_done and out_error are 0. out_if_rdata and out_dm_rdata carry in_mem_rdata but are qualified by the valid/done strobes.
- Minimum access latency is 2 cycles. A request seen in IDLE at cycle t gives out_mem_req=1 at t+1, and completion at t+1 if in_mem_ready=1.
- A memory with W wait cycles completes at t+1+W.
- Back-to-back accesses have one IDLE cycle between them.
- in_mem_ready is ignored outside FETCH/DATA.
- TIMEOUT=N: out_error rises on the clock edge after the Nth consecutive not-ready cycle in FETCH/DATA.

## Test plan
- Fetch with zero wait: in_if_req=1, addr 0x100, in_mem_ready=1 on the first req cycle -> out_mem_req at cycle 1, out_if_valid=1 at cycle 1, out_stall_if high at cycle 0 only.
- Load with 3 wait cycles: in_dm_read, addr 0x2000, rdata 0xDEADBEEF -> out_stall_mem high for 4 cycles, out_dm_done and rdata 0xDEADBEEF in cycle 4, out_mem_addr stable throughout.
- Simultaneous store and fetch: store to 0x40 granted first with out_mem_we=1; fetch issued after one IDLE cycle; out_stall_if held until fetch completion.
- Flush mid-fetch: in_flush pulsed while FETCH waits -> access completes on ready, out_if_valid stays 0, next fetch uses the new PC.
- Timeout: TIMEOUT=4, in_mem_ready held 0 -> out_error=1 after 4 wait cycles, out_mem_req=0, stalls stay high; after reset, out_error=0 and FSM in IDLE.
- Reset mid-access: in_rst_n low during DATA -> out_mem_req=0 immediately. The first request after release is granted normally.
